inference_sequencer: RTL and testbench

//  Frame-level controller in front of the conv_pooling_top -> dnn_top pipeline.

---
 rtl/inference_seq_pkg.sv | 7 +
 rtl/seq_watchdog.sv | 19 +
 rtl/inference_sequencer.sv | 94 +++++++++
 tb/tb_inference_sequencer.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/inference_seq_pkg.sv
// inference_seq_pkg: frame sequencer state encoding and counter sizing helper
package inference_seq_pkg;
  typedef enum logic [2:0] {IDLE, LOAD, DRAIN, FLUSH, WAIT_DNN, DONE} seq_state_t;
  function automatic int cnt_w(input int n);
    return ($clog2(n + 1) < 1) ? 1 : $clog2(n + 1);
  endfunction
endpackage

// File: rtl/seq_watchdog.sv
// seq_watchdog: counts enabled cycles since clear and flags the last cycle before the limit
module seq_watchdog #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         res_n,
  input  logic         clear,
  input  logic         enable,
  input  logic [W-1:0] limit,
  output logic         expire
);
  logic [W-1:0] cnt;
  assign expire = enable && (limit != '0) && (cnt == limit - W'(1));
  // cycle counter, restarted whenever the watched window is left
  always_ff @(posedge clk or negedge res_n)
    if (!res_n) cnt <= '0;
    else if (clear) cnt <= '0;
    else if (enable) cnt <= cnt + W'(1);
endmodule

// File: rtl/inference_sequencer.sv
// inference_sequencer: per-frame controller feeding pixels to conv and timing the DNN flush
module inference_sequencer
  import inference_seq_pkg::*;
#(
  parameter int BitSize       = 32,
  parameter int ImageWidth    = 8,
  parameter int C2NumberOfK   = 4,
  parameter int MaxNumNerves  = 6,
  parameter int TimeoutCycles = 4096,
  parameter int FrameCntBits  = 8
) (
  input  logic                    clk,
  input  logic                    res_n,
  input  logic                    start,
  input  logic                    src_valid,
  input  logic [BitSize-1:0]      src_data,
  output logic                    src_ready,
  input  logic                    conv_ready,
  output logic                    conv_in_valid,
  output logic [BitSize-1:0]      conv_in_data,
  input  logic                    conv_set_done,
  output logic                    dnn_fl_res,
  input  logic                    dnn_out_done,
  output logic                    busy,
  output logic                    frame_done,
  output logic                    timeout_err,
  output logic [FrameCntBits-1:0] frame_cnt
);
  localparam int NumPixels  = ImageWidth ** 2;
  localparam int FlushDelay = C2NumberOfK + MaxNumNerves;
  localparam int PW = cnt_w(NumPixels);
  localparam int FW = cnt_w(FlushDelay);
  localparam int WW = cnt_w(TimeoutCycles);
  seq_state_t state, state_nx;
  logic [PW-1:0] pix_cnt;
  logic [FW-1:0] fl_cnt;
  logic set_done_seen, transfer, in_wd, expire;
  assign src_ready = (state == LOAD) && conv_ready;
  assign transfer  = src_valid && src_ready;
  assign busy      = state != IDLE;
  assign in_wd     = (state == DRAIN) || (state == WAIT_DNN);
  seq_watchdog #(.W(WW)) u_wd (
    .clk(clk),
    .res_n(res_n),
    .clear(!in_wd),
    .enable(in_wd),
    .limit(WW'(TimeoutCycles)),
    .expire(expire)
  );
  // next state; a pipeline exit condition beats a same-cycle watchdog expiry
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:     state_nx = start ? LOAD : IDLE;
      LOAD:     state_nx = (transfer && pix_cnt == PW'(NumPixels - 1)) ? DRAIN : LOAD;
      DRAIN:    state_nx = (conv_set_done || set_done_seen) ? FLUSH : expire ? IDLE : DRAIN;
      FLUSH:    state_nx = (fl_cnt == FW'(FlushDelay)) ? WAIT_DNN : FLUSH;
      WAIT_DNN: state_nx = dnn_out_done ? DONE : expire ? IDLE : WAIT_DNN;
      DONE:     state_nx = IDLE;
      default:  state_nx = IDLE;
    endcase
  end
  // state register, pixel pipeline stage, counters and registered pulses
  always_ff @(posedge clk or negedge res_n)
    if (!res_n) begin
      state         <= IDLE;
      pix_cnt       <= '0;
      fl_cnt        <= '0;
      set_done_seen <= 1'b0;
      conv_in_valid <= 1'b0;
      conv_in_data  <= '0;
      dnn_fl_res    <= 1'b0;
      frame_done    <= 1'b0;
      timeout_err   <= 1'b0;
      frame_cnt     <= '0;
    end else begin
      state         <= state_nx;
      conv_in_valid <= transfer;
      dnn_fl_res    <= (state == FLUSH) && (fl_cnt == FW'(FlushDelay));
      frame_done    <= state == DONE;
      if (transfer) conv_in_data <= src_data;
      if (state == IDLE && start) begin
        pix_cnt       <= '0;
        timeout_err   <= 1'b0;
        set_done_seen <= 1'b0;
      end
      if (transfer) pix_cnt <= pix_cnt + PW'(1);
      if (state == LOAD && conv_set_done) set_done_seen <= 1'b1;
      if (state == DRAIN) fl_cnt <= '0;
      else if (state == FLUSH) fl_cnt <= fl_cnt + FW'(1);
      if (in_wd && state_nx == IDLE) timeout_err <= 1'b1;
      if (state == DONE) frame_cnt <= frame_cnt + FrameCntBits'(1);
    end
endmodule

// File: tb/tb_inference_sequencer.sv
// tb_inference_sequencer: randomized frame scenarios checked against a frame-level model
`timescale 1ns/1ps
module tb_inference_sequencer;
  localparam int BW = 32, IW = 8, NK = 4, MN = 6, TO = 16, FB = 8;
  localparam int NPIX = IW * IW;
  localparam int FD = NK + MN;
  logic clk = 1'b0, res_n = 1'b0, start = 1'b0, src_valid = 1'b0, conv_ready = 1'b0;
  logic conv_set_done = 1'b0, dnn_out_done = 1'b0;
  logic [BW-1:0] src_data = '0;
  logic src_ready, conv_in_valid, dnn_fl_res, busy, frame_done, timeout_err;
  logic [BW-1:0] conv_in_data;
  logic [FB-1:0] frame_cnt;
  int checks = 0, errors = 0, frames = 0;

  always #5 clk = ~clk;

  inference_sequencer #(
    .BitSize(BW), .ImageWidth(IW), .C2NumberOfK(NK), .MaxNumNerves(MN),
    .TimeoutCycles(TO), .FrameCntBits(FB)
  ) dut (
    .clk(clk), .res_n(res_n), .start(start), .src_valid(src_valid), .src_data(src_data),
    .src_ready(src_ready), .conv_ready(conv_ready), .conv_in_valid(conv_in_valid),
    .conv_in_data(conv_in_data), .conv_set_done(conv_set_done), .dnn_fl_res(dnn_fl_res),
    .dnn_out_done(dnn_out_done), .busy(busy), .frame_done(frame_done),
    .timeout_err(timeout_err), .frame_cnt(frame_cnt)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    tick;
    checks++;
    if ({src_ready, conv_in_valid, dnn_fl_res, busy, frame_done, timeout_err} !== 6'b0 ||
        conv_in_data !== '0 || frame_cnt !== '0) begin
      errors++;
      $display("FAIL reset_outputs got flags=%b data=%0h cnt=%0d want all 0",
               {src_ready, conv_in_valid, dnn_fl_res, busy, frame_done, timeout_err}, conv_in_data, frame_cnt);
    end
    res_n = 1'b1;
    tick;
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL idle_after_reset busy=%b want 0", busy); end
  endtask

  // mode 0: full rate, 1: conv_ready toggling, 2: random valid/ready with ignored start/dnn_out_done noise
  task automatic load_frame(input int mode, input int sd_at, input int abort_at);
    logic [BW-1:0] exp_q[$];
    logic [BW-1:0] got_q[$];
    logic [BW-1:0] px;
    int idx, cyc, bad;
    bit acc;
    idx = 0; cyc = 0; bad = 0; px = $urandom;
    start = 1'b1;
    tick;
    start = 1'b0;
    checks++;
    if (busy !== 1'b1 || timeout_err !== 1'b0) begin
      errors++; $display("FAIL start_load busy=%b timeout_err=%b want 1/0", busy, timeout_err);
    end
    while (idx < NPIX && cyc < 4000) begin
      src_valid     = (mode == 2) ? ($urandom_range(0, 3) != 0) : 1'b1;
      conv_ready    = (mode == 0) ? 1'b1 : (mode == 1) ? (cyc % 2 == 0) : ($urandom_range(0, 2) != 0);
      src_data      = src_valid ? px : $urandom;
      conv_set_done = (idx == sd_at);
      start         = (mode == 2) && ($urandom_range(0, 1) == 1);
      dnn_out_done  = (mode == 2) && ($urandom_range(0, 1) == 1);
      #1;
      checks++;
      if (src_ready !== conv_ready) begin
        errors++; $display("FAIL src_ready pix=%0d got %b want %b", idx, src_ready, conv_ready);
      end
      if (idx == abort_at) begin
        #1;
        res_n = 1'b0;
        #1;
        checks++;
        if ({src_ready, conv_in_valid, dnn_fl_res, busy, frame_done, timeout_err} !== 6'b0 ||
            conv_in_data !== '0 || frame_cnt !== '0) begin
          errors++;
          $display("FAIL async_reset got flags=%b data=%0h cnt=%0d want all 0",
                   {src_ready, conv_in_valid, dnn_fl_res, busy, frame_done, timeout_err}, conv_in_data, frame_cnt);
        end
        res_n = 1'b1; frames = 0;
        start = 1'b0; src_valid = 1'b0; conv_set_done = 1'b0; dnn_out_done = 1'b0;
        tick;
        return;
      end
      acc = src_valid && conv_ready;
      if (acc) begin exp_q.push_back(px); idx++; px = $urandom; end
      tick;
      cyc++;
      checks++;
      if (conv_in_valid !== acc) begin
        errors++; $display("FAIL conv_in_valid cyc=%0d got %b want %b", cyc, conv_in_valid, acc);
      end
      if (conv_in_valid === 1'b1) got_q.push_back(conv_in_data);
    end
    src_valid = 1'b0; conv_ready = 1'b1; conv_set_done = 1'b0; start = 1'b0; dnn_out_done = 1'b0;
    #1;
    checks++;
    if (src_ready !== 1'b0 || busy !== 1'b1) begin
      errors++; $display("FAIL drain_entry src_ready=%b busy=%b want 0/1", src_ready, busy);
    end
    if (got_q.size() == NPIX) for (int i = 0; i < NPIX; i++) if (got_q[i] !== exp_q[i]) bad++;
    checks++;
    if (got_q.size() != NPIX || bad != 0) begin
      errors++; $display("FAIL pixel_stream beats=%0d wrong=%0d want %0d/0", got_q.size(), bad, NPIX);
    end
  endtask

  // called in DRAIN cycle 1; set_done arrives after d DRAIN cycles unless already latched in LOAD
  task automatic run_flush(input int d, input bit latched);
    int first, pulses;
    first = -1; pulses = 0;
    for (int i = 1; i <= d + 14; i++) begin
      conv_set_done = !latched && (i == d + 1);
      tick;
      if (dnn_fl_res === 1'b1) begin pulses++; if (first < 0) first = i; end
    end
    conv_set_done = 1'b0;
    checks++;
    if (first != d + FD + 2 || pulses != 1) begin
      errors++; $display("FAIL flush_pulse at=%0d pulses=%0d want %0d/1", first, pulses, d + FD + 2);
    end
    checks++;
    if (busy !== 1'b1) begin errors++; $display("FAIL wait_dnn busy=%b want 1", busy); end
  endtask

  // called in WAIT_DNN cycle 3
  task automatic finish_frame(input int extra);
    repeat (extra) tick;
    dnn_out_done = 1'b1;
    tick;
    dnn_out_done = 1'b0;
    checks++;
    if (busy !== 1'b1 || frame_done !== 1'b0 || timeout_err !== 1'b0) begin
      errors++; $display("FAIL done_state busy=%b frame_done=%b timeout_err=%b want 1/0/0", busy, frame_done, timeout_err);
    end
    tick;
    frames++;
    checks++;
    if (frame_done !== 1'b1 || busy !== 1'b0 || frame_cnt !== FB'(frames)) begin
      errors++; $display("FAIL frame_done pulse=%b busy=%b cnt=%0d want 1/0/%0d", frame_done, busy, frame_cnt, FB'(frames));
    end
    tick;
    checks++;
    if (frame_done !== 1'b0) begin errors++; $display("FAIL frame_done_width got %b want 0", frame_done); end
  endtask

  task automatic test_stream_full;
    load_frame(0, -1, -1);
    run_flush(5, 1'b0);
    finish_frame(0);
  endtask

  task automatic test_backpressure;
    load_frame(1, -1, -1);
    run_flush(TO - 1, 1'b0);
    finish_frame(TO - 3);
  endtask

  task automatic test_random_latched;
    load_frame(2, 20, -1);
    run_flush(0, 1'b1);
    finish_frame($urandom_range(0, 8));
  endtask

  task automatic test_timeout;
    load_frame(0, -1, -1);
    repeat (TO - 1) tick;
    checks++;
    if (busy !== 1'b1 || timeout_err !== 1'b0) begin
      errors++; $display("FAIL drain_before_limit busy=%b timeout_err=%b want 1/0", busy, timeout_err);
    end
    tick;
    checks++;
    if (busy !== 1'b0 || timeout_err !== 1'b1 || frame_done !== 1'b0 || frame_cnt !== FB'(frames)) begin
      errors++; $display("FAIL drain_timeout busy=%b err=%b done=%b cnt=%0d want 0/1/0/%0d",
                         busy, timeout_err, frame_done, frame_cnt, FB'(frames));
    end
    tick;
    checks++;
    if (timeout_err !== 1'b1 || frame_done !== 1'b0) begin
      errors++; $display("FAIL timeout_sticky err=%b done=%b want 1/0", timeout_err, frame_done);
    end
    load_frame(2, -1, -1);
    run_flush(3, 1'b0);
    repeat (TO - 3) tick;
    checks++;
    if (busy !== 1'b1) begin errors++; $display("FAIL wait_before_limit busy=%b want 1", busy); end
    tick;
    checks++;
    if (busy !== 1'b0 || timeout_err !== 1'b1 || frame_done !== 1'b0 || frame_cnt !== FB'(frames)) begin
      errors++; $display("FAIL wait_timeout busy=%b err=%b done=%b cnt=%0d want 0/1/0/%0d",
                         busy, timeout_err, frame_done, frame_cnt, FB'(frames));
    end
  endtask

  task automatic test_back_to_back_wrap;
    int cyc;
    src_valid = 1'b1; conv_ready = 1'b1; conv_set_done = 1'b1; dnn_out_done = 1'b1; start = 1'b1;
    for (int f = 0; f < 256; f++) begin
      cyc = 0;
      do begin src_data = $urandom; tick; cyc++; end while (frame_done !== 1'b1 && cyc < 300);
      if (f == 255) start = 1'b0;
      frames++;
      checks++;
      if (frame_done !== 1'b1 || frame_cnt !== FB'(frames)) begin
        errors++; $display("FAIL wrap_frame f=%0d done=%b cnt=%0d want 1/%0d", f, frame_done, frame_cnt, FB'(frames));
        break;
      end
    end
    start = 1'b0; src_valid = 1'b0; conv_set_done = 1'b0; dnn_out_done = 1'b0;
    tick;
    tick;
    checks++;
    if (busy !== 1'b0 || frame_cnt !== FB'(frames)) begin
      errors++; $display("FAIL wrap_end busy=%b cnt=%0d want 0/%0d", busy, frame_cnt, FB'(frames));
    end
  endtask

  task automatic test_reset_mid_load;
    load_frame(0, -1, 30);
    load_frame(2, -1, -1);
    run_flush(1, 1'b0);
    finish_frame(1);
  endtask

  initial begin
    test_reset;
    test_stream_full;
    test_backpressure;
    test_random_latched;
    test_timeout;
    test_back_to_back_wrap;
    test_reset_mid_load;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL global_timeout simulation did not complete, checks=%0d", checks);
    $fatal(1);
  end
endmodule
